// File: rtl/adc_burst_sequencer.sv
// Burst conversion scheduler: paces ADC start pulses, stores each returned sample in the burst RAM,
// and reports progress and overrun status to the CPU register bank.
module adc_burst_sequencer #(
    parameter int unsigned MaxADCBurstReadings = 13,
    parameter int unsigned SampleWidth         = 16,
    parameter int unsigned IntervalWidth       = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             start_i,
    input  logic                             abort_i,
    input  logic [MaxADCBurstReadings-1:0]   burst_len_i,
    input  logic [IntervalWidth-1:0]         interval_i,
    output logic                             adc_start_o,
    input  logic                             adc_done_i,
    input  logic [SampleWidth-1:0]           adc_data_i,
    output logic                             buf_we_o,
    output logic [MaxADCBurstReadings-2:0]   buf_addr_o,
    output logic [SampleWidth-1:0]           buf_wdata_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             overrun_o,
    output logic [MaxADCBurstReadings-1:0]   count_o
);

    localparam int unsigned CountWidth = MaxADCBurstReadings;
    localparam int unsigned AddrWidth  = MaxADCBurstReadings - 1;
    localparam logic [CountWidth-1:0] Depth = {1'b1, {AddrWidth{1'b0}}};

    typedef enum logic [1:0] {StIdle, StConvert, StWait, StDone} state_e;

    state_e                   r_state, w_state_d;
    logic [CountWidth-1:0]    r_len, w_len_d;
    logic [IntervalWidth-1:0] r_interval, w_interval_d;
    logic [IntervalWidth-1:0] r_timer, w_timer_d;
    logic [CountWidth-1:0]    r_count, w_count_d;
    logic [AddrWidth-1:0]     r_addr, w_addr_d;
    logic [SampleWidth-1:0]   r_wdata, w_wdata_d;
    logic                     r_adc_start, w_adc_start_d;
    logic                     r_we, w_we_d;
    logic                     r_busy, w_busy_d;
    logic                     r_done, w_done_d;
    logic                     r_overrun, w_overrun_d;

    logic [CountWidth-1:0]    w_len_clamped;
    logic [CountWidth-1:0]    w_count_inc;
    logic [IntervalWidth:0]   w_timer_next;

    assign w_len_clamped = (burst_len_i > Depth) ? Depth : burst_len_i;
    assign w_count_inc   = r_count + CountWidth'(1);
    // Timer value the cycle after this one; one bit wider so the compare never wraps.
    assign w_timer_next  = {1'b0, r_timer} + (IntervalWidth + 1)'(1);

    always_comb begin
        w_state_d     = r_state;
        w_len_d       = r_len;
        w_interval_d  = r_interval;
        w_count_d     = r_count;
        w_addr_d      = r_addr;
        w_wdata_d     = r_wdata;
        w_adc_start_d = 1'b0;
        w_we_d        = 1'b0;
        w_done_d      = r_done;
        w_overrun_d   = r_overrun;

        unique case (r_state)
            StIdle: begin
                if (start_i && !abort_i) begin
                    w_len_d      = w_len_clamped;
                    w_interval_d = interval_i;
                    w_count_d    = '0;
                    w_overrun_d  = 1'b0;
                    if (w_len_clamped == '0) begin
                        w_done_d = 1'b1;
                    end else begin
                        w_done_d      = 1'b0;
                        w_adc_start_d = 1'b1;
                        w_state_d     = StConvert;
                    end
                end
            end
            StConvert: begin
                if ((r_interval != '0) && (r_timer >= r_interval)) begin
                    w_overrun_d = 1'b1;
                end
                if (adc_done_i) begin
                    w_we_d    = 1'b1;
                    w_addr_d  = r_count[AddrWidth-1:0];
                    w_wdata_d = adc_data_i;
                    w_count_d = w_count_inc;
                    w_state_d = (w_count_inc == r_len) ? StDone : StWait;
                end
            end
            StWait: begin
                if (w_timer_next >= {1'b0, r_interval}) begin
                    w_adc_start_d = 1'b1;
                    w_state_d     = StConvert;
                end
            end
            StDone: begin
                w_done_d  = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase

        // Abort stops scheduling immediately but lets an already-captured sample land.
        if (abort_i) begin
            w_state_d     = StIdle;
            w_adc_start_d = 1'b0;
            w_done_d      = r_done;
            w_overrun_d   = r_overrun;
        end

        if (w_adc_start_d) begin
            w_timer_d = '0;
        end else if (&r_timer) begin
            w_timer_d = r_timer;
        end else begin
            w_timer_d = w_timer_next[IntervalWidth-1:0];
        end

        w_busy_d = (w_state_d != StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= StIdle;
            r_len       <= '0;
            r_interval  <= '0;
            r_timer     <= '0;
            r_count     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_adc_start <= 1'b0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_len       <= w_len_d;
            r_interval  <= w_interval_d;
            r_timer     <= w_timer_d;
            r_count     <= w_count_d;
            r_addr      <= w_addr_d;
            r_wdata     <= w_wdata_d;
            r_adc_start <= w_adc_start_d;
            r_we        <= w_we_d;
            r_busy      <= w_busy_d;
            r_done      <= w_done_d;
            r_overrun   <= w_overrun_d;
        end
    end

    assign adc_start_o = r_adc_start;
    assign buf_we_o    = r_we;
    assign buf_addr_o  = r_addr;
    assign buf_wdata_o = r_wdata;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign overrun_o   = r_overrun;
    assign count_o     = r_count;

endmodule

// File: tb/tb_adc_burst_sequencer.sv
// Directed bench for adc_burst_sequencer with a fixed-latency ADC model and an event monitor.
module tb_adc_burst_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [12:0] burst_len_i = '0;
    logic [15:0] interval_i = '0;
    logic        adc_start_o;
    logic        adc_done_i = 1'b0;
    logic [15:0] adc_data_i = '0;
    logic        buf_we_o;
    logic [11:0] buf_addr_o;
    logic [15:0] buf_wdata_o;
    logic        busy_o;
    logic        done_o;
    logic        overrun_o;
    logic [12:0] count_o;

    adc_burst_sequencer dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .burst_len_i (burst_len_i),
        .interval_i  (interval_i),
        .adc_start_o (adc_start_o),
        .adc_done_i  (adc_done_i),
        .adc_data_i  (adc_data_i),
        .buf_we_o    (buf_we_o),
        .buf_addr_o  (buf_addr_o),
        .buf_wdata_o (buf_wdata_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overrun_o   (overrun_o),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Monitor / ADC model state
    int cyc = 0;
    int adc_d = 20;
    bit pend = 0;
    int done_at = 0;
    int n_done = 0;
    int nstarts = 0;
    int first_start = 0;
    int last_start = 0;
    int min_sp = 0;
    int max_sp = 0;
    int nwr = 0;
    int wr_err = 0;
    int lat_err = 0;
    int last_done_cyc = -10;
    int last_wr_cyc = 0;
    int last_addr = 0;
    int done_rise = 0;
    bit prev_done = 0;
    bit busy_seen = 0;

    always @(posedge clk_i) begin
        #1;
        cyc = cyc + 1;
        if (adc_start_o) begin
            if (nstarts == 0) first_start = cyc;
            else begin
                if (cyc - last_start < min_sp) min_sp = cyc - last_start;
                if (cyc - last_start > max_sp) max_sp = cyc - last_start;
            end
            last_start = cyc;
            nstarts = nstarts + 1;
        end
        if (buf_we_o) begin
            if (int'(buf_addr_o) != nwr || buf_wdata_o != 16'(16'h1000 + nwr)) wr_err = wr_err + 1;
            if (cyc != last_done_cyc + 1) lat_err = lat_err + 1;
            last_addr = int'(buf_addr_o);
            last_wr_cyc = cyc;
            nwr = nwr + 1;
        end
        if (busy_o) busy_seen = 1;
        if (done_o && !prev_done) done_rise = cyc;
        prev_done = done_o;
        // ADC model: answer each start D cycles later
        adc_done_i = 1'b0;
        if (pend && cyc == done_at) begin
            adc_done_i = 1'b1;
            adc_data_i = 16'(16'h1000 + n_done);
            n_done = n_done + 1;
            last_done_cyc = cyc;
            pend = 0;
        end
        if (adc_start_o) begin
            pend = 1;
            done_at = cyc + adc_d;
        end
    end

    task automatic clear_log(input int d);
        adc_d = d; pend = 0; n_done = 0; nstarts = 0; min_sp = 1000000; max_sp = 0;
        nwr = 0; wr_err = 0; lat_err = 0; busy_seen = 0; done_rise = 0;
    endtask

    task automatic pulse_start(input int len, input int intv, output int set_cyc);
        @(negedge clk_i);
        burst_len_i = 13'(len);
        interval_i = 16'(intv);
        start_i = 1'b1;
        set_cyc = cyc;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        total_cnt++;
        if ({adc_start_o, buf_we_o, buf_addr_o, buf_wdata_o, busy_o, done_o, overrun_o, count_o} !== '0)
            $display("FAIL reset_outputs: got %0h want 0",
                {adc_start_o, buf_we_o, buf_addr_o, buf_wdata_o, busy_o, done_o, overrun_o, count_o});
        else pass_cnt++;
        reset_i = 1'b0;
    endtask

    task automatic test_basic();
        int sc; bit ok;
        clear_log(20);
        pulse_start(4, 100, sc);
        wait_done(600, ok);
        total_cnt++; if (ok !== 1'b1) $display("FAIL basic_timeout: got %0d want 1", ok); else pass_cnt++;
        total_cnt++; if (first_start != sc + 1) $display("FAIL basic_first_start: got %0d want %0d", first_start, sc + 1); else pass_cnt++;
        total_cnt++; if (nstarts != 4) $display("FAIL basic_nstarts: got %0d want 4", nstarts); else pass_cnt++;
        total_cnt++; if (min_sp != 100 || max_sp != 100) $display("FAIL basic_spacing: got %0d..%0d want 100", min_sp, max_sp); else pass_cnt++;
        total_cnt++; if (nwr != 4) $display("FAIL basic_writes: got %0d want 4", nwr); else pass_cnt++;
        total_cnt++; if (wr_err != 0) $display("FAIL basic_addr_data: got %0d errors want 0", wr_err); else pass_cnt++;
        total_cnt++; if (lat_err != 0) $display("FAIL basic_write_latency: got %0d errors want 0", lat_err); else pass_cnt++;
        total_cnt++; if (done_rise != last_wr_cyc + 1) $display("FAIL basic_done_timing: got %0d want %0d", done_rise, last_wr_cyc + 1); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL basic_busy: got %0b want 0", busy_o); else pass_cnt++;
        total_cnt++; if (count_o !== 13'd4) $display("FAIL basic_count: got %0d want 4", count_o); else pass_cnt++;
        total_cnt++; if (overrun_o !== 1'b0) $display("FAIL basic_overrun: got %0b want 0", overrun_o); else pass_cnt++;
    endtask

    task automatic test_overrun();
        int sc; bit ok;
        clear_log(20);
        pulse_start(3, 10, sc);
        wait_done(300, ok);
        total_cnt++; if (ok !== 1'b1) $display("FAIL ovr_timeout: got %0d want 1", ok); else pass_cnt++;
        total_cnt++; if (overrun_o !== 1'b1) $display("FAIL ovr_flag: got %0b want 1", overrun_o); else pass_cnt++;
        total_cnt++; if (min_sp != 22 || max_sp != 22) $display("FAIL ovr_spacing: got %0d..%0d want 22", min_sp, max_sp); else pass_cnt++;
        total_cnt++; if (nwr != 3 || wr_err != 0) $display("FAIL ovr_writes: got %0d (err %0d) want 3", nwr, wr_err); else pass_cnt++;
        total_cnt++; if (count_o !== 13'd3) $display("FAIL ovr_count: got %0d want 3", count_o); else pass_cnt++;
    endtask

    task automatic test_len_zero();
        int sc;
        clear_log(4);
        pulse_start(0, 50, sc);
        total_cnt++; if (done_o !== 1'b1 || busy_o !== 1'b0) $display("FAIL len0_done: got done=%0b busy=%0b want 1/0", done_o, busy_o); else pass_cnt++;
        total_cnt++; if (overrun_o !== 1'b0 || count_o !== '0) $display("FAIL len0_cleared: got ovr=%0b cnt=%0d want 0/0", overrun_o, count_o); else pass_cnt++;
        repeat (20) @(negedge clk_i);
        total_cnt++; if (nstarts != 0 || busy_seen != 0) $display("FAIL len0_quiet: got starts=%0d busy_seen=%0d want 0/0", nstarts, busy_seen); else pass_cnt++;
    endtask

    task automatic test_clamp();
        int sc; bit ok;
        clear_log(4);
        pulse_start(5000, 0, sc);
        wait_done(30000, ok);
        total_cnt++; if (ok !== 1'b1) $display("FAIL clamp_timeout: got %0d want 1", ok); else pass_cnt++;
        total_cnt++; if (nwr != 4096 || wr_err != 0) $display("FAIL clamp_writes: got %0d (err %0d) want 4096", nwr, wr_err); else pass_cnt++;
        total_cnt++; if (last_addr != 32'hFFF) $display("FAIL clamp_last_addr: got %0h want fff", last_addr); else pass_cnt++;
        total_cnt++; if (count_o !== 13'd4096) $display("FAIL clamp_count: got %0d want 4096", count_o); else pass_cnt++;
        total_cnt++; if (min_sp != 6 || max_sp != 6) $display("FAIL clamp_spacing: got %0d..%0d want 6", min_sp, max_sp); else pass_cnt++;
    endtask

    task automatic test_abort();
        int sc; bit ok;
        clear_log(20);
        pulse_start(4, 30, sc);
        for (int i = 0; i < 200 && nstarts < 2; i++) @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL abort_busy: got %0b want 0", busy_o); else pass_cnt++;
        repeat (40) @(negedge clk_i);
        total_cnt++; if (nstarts != 2) $display("FAIL abort_nstarts: got %0d want 2", nstarts); else pass_cnt++;
        total_cnt++; if (nwr != 1 || count_o !== 13'd1) $display("FAIL abort_count: got wr=%0d cnt=%0d want 1/1", nwr, count_o); else pass_cnt++;
        total_cnt++; if (done_o !== 1'b0) $display("FAIL abort_done: got %0b want 0", done_o); else pass_cnt++;
        clear_log(4);
        pulse_start(2, 0, sc);
        wait_done(100, ok);
        total_cnt++; if (ok !== 1'b1 || nwr != 2 || wr_err != 0) $display("FAIL abort_restart: got ok=%0d wr=%0d err=%0d want 1/2/0", ok, nwr, wr_err); else pass_cnt++;
    endtask

    task automatic test_ignore_and_reset();
        int sc; bit ok;
        clear_log(5);
        pulse_start(2, 50, sc);
        repeat (3) @(negedge clk_i);
        pulse_start(7, 10, sc);
        wait_done(300, ok);
        total_cnt++; if (ok !== 1'b1 || count_o !== 13'd2 || nstarts != 2) $display("FAIL busy_start_ignored: got cnt=%0d starts=%0d want 2/2", count_o, nstarts); else pass_cnt++;
        clear_log(5);
        @(negedge clk_i);
        burst_len_i = 13'd3; start_i = 1'b1; abort_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; abort_i = 1'b0;
        repeat (10) @(negedge clk_i);
        total_cnt++; if (nstarts != 0 || busy_seen != 0) $display("FAIL start_abort_idle: got starts=%0d busy_seen=%0d want 0/0", nstarts, busy_seen); else pass_cnt++;
        total_cnt++; if (done_o !== 1'b1 || count_o !== 13'd2) $display("FAIL start_abort_hold: got done=%0b cnt=%0d want 1/2", done_o, count_o); else pass_cnt++;
        clear_log(10);
        pulse_start(3, 40, sc);
        for (int i = 0; i < 50 && nstarts < 1; i++) @(negedge clk_i);
        repeat (3) @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        total_cnt++;
        if ({adc_start_o, buf_we_o, buf_addr_o, buf_wdata_o, busy_o, done_o, overrun_o, count_o} !== '0)
            $display("FAIL midburst_reset: got %0h want 0",
                {adc_start_o, buf_we_o, buf_addr_o, buf_wdata_o, busy_o, done_o, overrun_o, count_o});
        else pass_cnt++;
        repeat (20) @(negedge clk_i);
        total_cnt++; if (nwr != 0 || count_o !== '0 || busy_o !== 1'b0) $display("FAIL reset_late_done: got wr=%0d cnt=%0d busy=%0b want 0/0/0", nwr, count_o, busy_o); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_len_zero();
        test_clamp();
        test_abort();
        test_ignore_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
